sys1_input_cond: RTL

- Control-conditioning stage directly upstream of the System 1 game core's INP0/INP1/INP2 and pause inputs, and directly downstream of the HVGEN RGB output.
- Debounces coin/start/pause buttons and shapes coin into frame-timed pulses.
- Builds the active-low input bytes per cabinet mode (standard, dual-stick, spinner).
- Owns the user-pause toggle and the paused-screen dimming of the 8-bit RGB stream.

---
 rtl/sys1_input_cond.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sys1_input_cond.sv
// sys1_input_cond: button debounce, coin pulse shaping, cabinet input mapping, user pause and RGB dimming.
// Optional macro SYS1_PAUSE_INPUT_FREEZE_EN: while paused, input bytes read idle and the coin FSM holds.
module sys1_input_cond #(
    parameter int unsigned DB_CYCLES   = 48000,
    parameter int unsigned COIN_FRAMES = 3,
    parameter int unsigned DIM_CYCLES  = 480000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] joy,
    input  logic [7:0]  spin,
    input  logic [2:0]  mouse_btn,
    input  logic [7:0]  sysmode,
    input  logic        vs,
    input  logic        hs_pause,
    input  logic [7:0]  rgb_in,
    output logic [7:0]  inp0,
    output logic [7:0]  inp1,
    output logic [7:0]  inp2,
    output logic        pause,
    output logic [7:0]  rgb_out
);

    localparam int unsigned NB   = 4;
    localparam int unsigned DB_W = $clog2(DB_CYCLES + 1);
    localparam int unsigned FC_W = $clog2(COIN_FRAMES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(COIN_FRAMES - 1);
    localparam logic [31:0]     DIM_MAX = 32'(DIM_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_GAP, S_WAIT} coin_state_e;

    logic [NB-1:0]   raw_c;
    logic [NB-1:0]   db_q, db_d;
    logic [DB_W-1:0] cnt_q [NB];
    logic [DB_W-1:0] cnt_d [NB];
    logic            vs_q, tick_q;
    logic            coin_prev_q, pz_prev_q;
    logic            coin_rise_c, pause_rise_c;
    coin_state_e     state_q, state_d;
    logic [FC_W-1:0] fcnt_q, fcnt_d;
    logic            hold_c, coin_c, t_c;
    logic            tog_q, tog_d, pause_q;
    logic [31:0]     tim_q, tim_d;
    logic [7:0]      inp01_q, inp01_d, inp2_q, inp2_d, rgb_q, rgb_d;
    logic            unused_c;

    // Debounced button order: [0] coin, [1] start1, [2] start2, [3] pause
    assign raw_c    = {joy[12], joy[10], joy[9], joy[11]};
    assign unused_c = ^{joy[15:13], sysmode[7:6], sysmode[4], sysmode[2:0]};

    always_comb begin
        db_d = db_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (raw_c[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign coin_rise_c  = db_q[0] & ~coin_prev_q;
    assign pause_rise_c = db_q[3] & ~pz_prev_q;

`ifdef SYS1_PAUSE_INPUT_FREEZE_EN
    assign hold_c = pause_q;
`else
    assign hold_c = 1'b0;
`endif

    // Coin pulse: COIN_FRAMES ticks high, COIN_FRAMES ticks low, then wait for release
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (!hold_c) begin
            case (state_q)
                S_IDLE: begin
                    if (coin_rise_c) begin
                        state_d = S_HIGH;
                        fcnt_d  = '0;
                    end
                end
                S_HIGH, S_GAP: begin
                    if (tick_q) begin
                        if (fcnt_q == FC_LAST) begin
                            state_d = (state_q == S_HIGH) ? S_GAP : S_WAIT;
                            fcnt_d  = '0;
                        end else begin
                            fcnt_d = fcnt_q + FC_W'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (!db_q[0]) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign coin_c = (state_q == S_HIGH);
    assign t_c    = joy[4] | (|mouse_btn);

    always_comb begin
        if (sysmode[5]) begin
            inp01_d = ~spin;
            inp2_d  = ~{t_c, t_c, db_q[2], db_q[1], 3'b000, coin_c};
        end else if (sysmode[3]) begin
            inp01_d = ~{joy[1], joy[0], joy[3], joy[2], joy[5], joy[4], joy[7], joy[6]};
            inp2_d  = ~{joy[8], joy[8], db_q[2], db_q[1], 3'b000, coin_c};
        end else begin
            inp01_d = ~{joy[1], joy[0], joy[3], joy[2], 1'b0, joy[5], joy[4], joy[6]};
            inp2_d  = ~{2'b00, db_q[2], db_q[1], 3'b000, coin_c};
        end
`ifdef SYS1_PAUSE_INPUT_FREEZE_EN
        if (pause_q) begin
            inp01_d = 8'hFF;
            inp2_d  = 8'hFF;
        end
`endif
    end

    // User pause toggle, saturating dim timer and half-brightness RGB
    always_comb begin
        tog_d = tog_q ^ pause_rise_c;
        tim_d = '0;
        if (tog_q) tim_d = (tim_q == DIM_MAX) ? tim_q : tim_q + 32'd1;
        if (tog_q && (tim_q == DIM_MAX)) begin
            rgb_d = {1'b0, rgb_in[7:6], 1'b0, rgb_in[4:3], 1'b0, rgb_in[1]};
        end else begin
            rgb_d = rgb_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            db_q        <= '0;
            for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
            vs_q        <= 1'b0;
            tick_q      <= 1'b0;
            coin_prev_q <= 1'b0;
            pz_prev_q   <= 1'b0;
            state_q     <= S_IDLE;
            fcnt_q      <= '0;
            tog_q       <= 1'b0;
            tim_q       <= '0;
            pause_q     <= 1'b0;
            inp01_q     <= 8'hFF;
            inp2_q      <= 8'hFF;
            rgb_q       <= '0;
        end else begin
            db_q        <= db_d;
            for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
            vs_q        <= vs;
            tick_q      <= vs & ~vs_q;
            coin_prev_q <= db_q[0];
            pz_prev_q   <= db_q[3];
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            tog_q       <= tog_d;
            tim_q       <= tim_d;
            pause_q     <= tog_q | hs_pause;
            inp01_q     <= inp01_d;
            inp2_q      <= inp2_d;
            rgb_q       <= rgb_d;
        end
    end

    assign inp0    = inp01_q;
    assign inp1    = inp01_q;
    assign inp2    = inp2_q;
    assign pause   = pause_q;
    assign rgb_out = rgb_q;

endmodule
